memory_cycle: RTL and testbench

MEMORY_CYCLE -- requirements
Module: memory_cycle

---
 rtl/memory_cycle.sv | 159 +++++++++++++++
 tb/tb_memory_cycle.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle.sv
// M-stage memory access unit: issues one load/store per instruction over a
// req/ack memory port and fills the MEM/WB pipeline register.
module memory_cycle #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        ValidW,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        mem_err
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] read_data;
    } wb_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          req_d, we_d, err_d, stall;
    logic [31:0]   addr_d, wdata_d;
    wb_t           wb_q, wb_d, wb_from_m;

    logic access, aligned, timeout_hit;

    assign access      = ValidM && (MemWriteM || ResultSrcM);
    assign aligned     = (ALU_ResultM[1:0] == 2'b00);
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // The M inputs are held by upstream for the whole access, so they are
    // used directly when the access completes rather than being copied.
    assign wb_from_m = '{
        valid:      ValidM,
        reg_write:  ValidM & RegWriteM,
        result_src: ResultSrcM,
        rd:         RD_M,
        pc_plus4:   PCPlus4M,
        alu_result: ALU_ResultM,
        read_data:  32'h0
    };

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state;
        cnt_d   = cnt;
        req_d   = mem_req;
        we_d    = mem_we;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        err_d   = 1'b0;
        stall   = 1'b0;
        wb_d    = '0;

        case (state)
            IDLE: begin
                if (!access) begin
                    wb_d = ValidM ? wb_from_m : '0;
                end else if (aligned) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = ALU_ResultM;
                    wdata_d = WriteDataM;
                    cnt_d   = '0;
                end else begin
                    err_d          = 1'b1;
                    wb_d           = wb_from_m;
                    wb_d.reg_write = 1'b0;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    wb_d           = wb_from_m;
                    wb_d.read_data = MemWriteM ? 32'h0 : mem_rdata;
                    req_d          = 1'b0;
                    we_d           = 1'b0;
                    state_d        = IDLE;
                end else if (timeout_hit) begin
                    wb_d           = wb_from_m;
                    wb_d.reg_write = 1'b0;
                    err_d          = 1'b1;
                    req_d          = 1'b0;
                    we_d           = 1'b0;
                    state_d        = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall must read 0 while reset is held, even with an access presented.
    assign StallM = rst & stall;

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values; reset clears all of them asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_err   <= 1'b0;
            wb_q      <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_err   <= err_d;
            wb_q      <= wb_d;
        end
    end

    assign ValidW      = wb_q.valid;
    assign RegWriteW   = wb_q.reg_write;
    assign ResultSrcW  = wb_q.result_src;
    assign RD_W        = wb_q.rd;
    assign PCPlus4W    = wb_q.pc_plus4;
    assign ALU_ResultW = wb_q.alu_result;
    assign ReadDataW   = wb_q.read_data;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed scenarios plus a randomized
// instruction stream scored against a transaction-level expectation model.
module tb_memory_cycle;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ValidM = 0, RegWriteM = 0, MemWriteM = 0, ResultSrcM = 0;
    logic [4:0]  RD_M = '0;
    logic [31:0] PCPlus4M = '0, ALU_ResultM = '0, WriteDataM = '0;
    logic        StallM, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        ValidW, RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    memory_cycle #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid, regw, memw, rsrc;
        logic [4:0]  rd;
        logic [31:0] pc, alu, wdata;
    } instr_t;

    typedef struct packed {
        logic        valid, regw, rsrc;
        logic [4:0]  rd;
        logic [31:0] pc, alu, rdata;
    } wb_t;

    typedef enum {PASS_THRU, COMPLETED, ABORTED} outcome_e;

    // Expected writeback record for an instruction given how its access ended.
    function automatic wb_t expect_wb(input instr_t in, input outcome_e oc, input logic [31:0] rdata);
        wb_t w;
        w.valid = in.valid;
        w.regw  = in.valid && in.regw && (oc != ABORTED);
        w.rsrc  = in.rsrc;
        w.rd    = in.rd;
        w.pc    = in.pc;
        w.alu   = in.alu;
        w.rdata = (oc == COMPLETED && !in.memw) ? rdata : 32'h0;
        return w;
    endfunction

    function automatic wb_t observed_wb();
        return '{ValidW, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW};
    endfunction

    function automatic instr_t rand_instr();
        instr_t in;
        in.valid = ($urandom_range(0, 7) != 0);
        in.memw  = ($urandom_range(0, 3) == 0);
        in.rsrc  = ($urandom_range(0, 2) == 0);
        in.regw  = in.memw ? 1'b0 : 1'($urandom);
        in.rd    = 5'($urandom);
        in.pc    = $urandom;
        in.wdata = $urandom;
        in.alu   = $urandom;
        if ($urandom_range(0, 3) != 0) in.alu[1:0] = 2'b00;
        return in;
    endfunction

    task automatic drive(input instr_t in);
        ValidM = in.valid; RegWriteM = in.regw; MemWriteM = in.memw; ResultSrcM = in.rsrc;
        RD_M = in.rd; PCPlus4M = in.pc; ALU_ResultM = in.alu; WriteDataM = in.wdata;
    endtask

    task automatic cmp_wb(input string name, input wb_t exp);
        wb_t obs;
        obs = observed_wb();
        checks++;
        if (!exp.valid) begin
            if ({obs.valid, obs.regw} !== 2'b00) begin
                errors++;
                $display("FAIL %s: ValidW/RegWriteW got %b expected 00", name, {obs.valid, obs.regw});
            end
        end else if (obs !== exp) begin
            errors++;
            $display("FAIL %s: wb got %h expected %h", name, obs, exp);
        end
    endtask

    // Presents one instruction and follows it to writeback. ack_delay is the
    // BUSY cycle index (0 = first) in which mem_ack is raised; >= TIMEOUT means never.
    task automatic issue(input instr_t in, input int ack_delay, input logic idle_ack);
        logic [31:0] rd_val;
        bit acc, mis;
        acc = in.valid && (in.memw || in.rsrc);
        mis = acc && (in.alu[1:0] != 2'b00);
        @(negedge clk);
        drive(in);
        mem_ack   = idle_ack;
        mem_rdata = $urandom;
        #1;
        checks++;
        if (StallM !== (acc && !mis)) begin
            errors++; $display("FAIL stall_idle: got %b expected %b", StallM, acc && !mis);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (!acc || mis) begin
            cmp_wb("wb_single", expect_wb(in, mis ? ABORTED : PASS_THRU, 32'h0));
            checks++;
            if ({mem_err, mem_req} !== {mis, 1'b0}) begin
                errors++; $display("FAIL err_req_single: got %b expected %b", {mem_err, mem_req}, {mis, 1'b0});
            end
        end else begin
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_err} !== {1'b1, in.memw, in.alu, in.wdata, 1'b0}) begin
                errors++;
                $display("FAIL req_issue: got %b %b %h %h err=%b expected 1 %b %h %h err=0",
                         mem_req, mem_we, mem_addr, mem_wdata, mem_err, in.memw, in.alu, in.wdata);
            end
            cmp_wb("bubble_issue", '0);
            for (int i = 0; i < TIMEOUT; i++) begin
                @(negedge clk);
                if (i == ack_delay) begin
                    rd_val = $urandom;
                    mem_ack = 1'b1; mem_rdata = rd_val;
                    #1;
                    checks++;
                    if (StallM !== 1'b0) begin errors++; $display("FAIL stall_ack: got %b expected 0", StallM); end
                    @(posedge clk); #1;
                    mem_ack = 1'b0;
                    cmp_wb("wb_ack", expect_wb(in, COMPLETED, rd_val));
                    checks++;
                    if ({mem_req, mem_err} !== 2'b00) begin
                        errors++; $display("FAIL req_err_ack: got %b expected 00", {mem_req, mem_err});
                    end
                    break;
                end
                #1;
                if (i == TIMEOUT - 1) begin
                    checks++;
                    if (StallM !== 1'b0) begin errors++; $display("FAIL stall_timeout: got %b expected 0", StallM); end
                    @(posedge clk); #1;
                    cmp_wb("wb_timeout", expect_wb(in, ABORTED, 32'h0));
                    checks++;
                    if ({mem_req, mem_err} !== 2'b01) begin
                        errors++; $display("FAIL req_err_timeout: got %b expected 01", {mem_req, mem_err});
                    end
                    break;
                end
                checks++;
                if (StallM !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1 (cycle %0d)", StallM, i); end
                @(posedge clk); #1;
                checks++;
                if ({mem_req, mem_we, mem_addr, mem_wdata, mem_err, ValidW, RegWriteW} !==
                    {1'b1, in.memw, in.alu, in.wdata, 1'b0, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL busy_hold: got req=%b we=%b addr=%h wd=%h err=%b vw=%b rw=%b (cycle %0d)",
                             mem_req, mem_we, mem_addr, mem_wdata, mem_err, ValidW, RegWriteW, i);
                end
            end
        end
    endtask

    function automatic instr_t mk(input logic v, rw, mw, rs, input logic [4:0] rd,
                                  input logic [31:0] pc, alu, wd);
        return '{v, rw, mw, rs, rd, pc, alu, wd};
    endfunction

    task automatic test_reset();
        drive(mk(1, 1, 0, 1, 5'd3, 32'h44, 32'h100, 32'h0));
        #3;
        checks++;
        if ({StallM, mem_req, mem_we, mem_addr, mem_wdata, ValidW, RegWriteW, ResultSrcW, RD_W,
             PCPlus4W, ALU_ResultW, ReadDataW, mem_err} !== '0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero during reset (StallM=%b mem_req=%b ValidW=%b)",
                               StallM, mem_req, ValidW);
        end
        @(negedge clk);
        drive('0);
        rst = 1'b1;
    endtask

    task automatic test_alu();
        issue(mk(1, 1, 0, 0, 5'd5, 32'h1004, 32'hF0, 32'h0), 0, 1'b0);
        issue(mk(0, 1, 0, 0, 5'd7, 32'h1008, 32'h12, 32'h0), 0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            instr_t in;
            in = rand_instr();
            in.memw = 1'b0; in.rsrc = 1'b0;
            issue(in, 0, 1'($urandom));
        end
    endtask

    task automatic test_load();
        issue(mk(1, 1, 0, 1, 5'd9, 32'h2004, 32'h100, 32'h0), 3, 1'b0);
    endtask

    task automatic test_store();
        issue(mk(1, 0, 1, 0, 5'd0, 32'h2008, 32'h200, 32'hAA), 1, 1'b0);
    endtask

    task automatic test_misaligned();
        issue(mk(1, 1, 0, 1, 5'd4, 32'h200C, 32'h102, 32'h0), 0, 1'b0);
        issue(mk(1, 0, 1, 0, 5'd0, 32'h2010, 32'h203, 32'h55), 0, 1'b0);
        issue(mk(1, 1, 0, 0, 5'd6, 32'h2014, 32'h30, 32'h0), 0, 1'b0);
    endtask

    task automatic test_timeout();
        issue(mk(1, 1, 0, 1, 5'd8, 32'h3004, 32'h400, 32'h0), TIMEOUT, 1'b0);
        issue(mk(1, 1, 0, 0, 5'd2, 32'h3008, 32'h44, 32'h0), 0, 1'b0);
        issue(mk(1, 1, 0, 1, 5'd8, 32'h300C, 32'h404, 32'h0), TIMEOUT - 1, 1'b0);
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        drive(mk(1, 1, 0, 1, 5'd11, 32'h4004, 32'h500, 32'h0));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, StallM, ValidW, mem_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_busy: req/stall/validw/err got %b expected 0000",
                               {mem_req, StallM, ValidW, mem_err});
        end
        @(negedge clk);
        drive('0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mem_req, mem_err, ValidW} !== 3'b000) begin
            errors++; $display("FAIL after_reset: req/err/validw got %b expected 000", {mem_req, mem_err, ValidW});
        end
        issue(mk(1, 1, 0, 0, 5'd5, 32'h4008, 32'hF0, 32'h0), 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            int d;
            d = ($urandom_range(0, 19) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
            issue(rand_instr(), d, 1'($urandom));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
